// File: rtl/eda_visited_bitmap.sv
// Visited-pixel bitmap for the regional-maxima flood engine: multi-port mark/query,
// sequential next-unvisited row scan, row-per-cycle clear. Optional counter: EDA_VISITED_CNT_EN.
module eda_visited_bitmap #(
    parameter int M          = 16,
    parameter int N          = 16,
    parameter int I_WIDTH    = 4,
    parameter int J_WIDTH    = 4,
    parameter int ADDR_WIDTH = 8,
    parameter int PORTS      = 9
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        clear_req,
    output logic                        clear_busy,
    input  logic [PORTS-1:0]            mark_valid,
    input  logic [PORTS*ADDR_WIDTH-1:0] mark_addr,
    input  logic [PORTS-1:0]            query_valid,
    input  logic [PORTS*ADDR_WIDTH-1:0] query_addr,
    output logic [PORTS-1:0]            query_visited,
    input  logic                        find_req,
    output logic                        find_ready,
    output logic                        find_valid,
    output logic                        find_none,
    output logic [I_WIDTH-1:0]          next_row,
    output logic [J_WIDTH-1:0]          next_col
`ifdef EDA_VISITED_CNT_EN
    ,
    output logic [$clog2(M*N+1)-1:0]    visited_cnt,
    output logic                        all_visited
`endif
);

    typedef enum logic [1:0] {IDLE, SCAN, CLEAR} state_t;

    localparam logic [I_WIDTH-1:0] LAST_ROW = I_WIDTH'(M-1);

    state_t                    state_q, state_d;
    logic [M-1:0][N-1:0]       bmp_q, bmp_d, set_mask;
    logic [I_WIDTH-1:0]        row_q, row_d, ptr_q, ptr_d, clr_q, clr_d;
    logic [PORTS-1:0]          qv_q, qv_d;
    logic [N-1:0]              cur_row;
    logic                      row_hit;
    logic [J_WIDTH-1:0]        zero_col;

    // Address decode by full compare: out-of-range {i,j} simply never matches a cell.
    always_comb begin
        set_mask = '0;
        qv_d     = '0;
        for (int p = 0; p < PORTS; p++) begin
            for (int r = 0; r < M; r++) begin
                for (int c = 0; c < N; c++) begin
                    if (mark_valid[p] && state_q != CLEAR &&
                        mark_addr[p*ADDR_WIDTH +: ADDR_WIDTH] == {I_WIDTH'(r), J_WIDTH'(c)})
                        set_mask[r][c] = 1'b1;
                    if (query_valid[p] && state_q != CLEAR &&
                        query_addr[p*ADDR_WIDTH +: ADDR_WIDTH] == {I_WIDTH'(r), J_WIDTH'(c)})
                        qv_d[p] = bmp_q[r][c];
                end
            end
        end
    end

    always_comb begin
        bmp_d = bmp_q;
        if (state_q == CLEAR) begin
            for (int r = 0; r < M; r++)
                if (clr_q == I_WIDTH'(r)) bmp_d[r] = '0;
        end else begin
            bmp_d = bmp_q | set_mask;
        end
    end

    always_comb begin
        cur_row  = '1;
        row_hit  = 1'b0;
        zero_col = '0;
        for (int r = 0; r < M; r++)
            if (row_q == I_WIDTH'(r)) cur_row = bmp_q[r];
        for (int c = N-1; c >= 0; c--) begin
            if (!cur_row[c]) begin
                row_hit  = 1'b1;
                zero_col = J_WIDTH'(c);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        ptr_d      = ptr_q;
        clr_d      = clr_q;
        find_valid = 1'b0;
        find_none  = 1'b0;
        next_row   = '0;
        next_col   = '0;
        case (state_q)
            IDLE: begin
                if (find_req) begin
                    state_d = SCAN;
                    row_d   = ptr_q;
                end
            end
            SCAN: begin
                if (row_hit) begin
                    find_valid = 1'b1;
                    next_row   = row_q;
                    next_col   = zero_col;
                    ptr_d      = row_q;
                    state_d    = IDLE;
                end else if (row_q == LAST_ROW) begin
                    find_valid = 1'b1;
                    find_none  = 1'b1;
                    ptr_d      = LAST_ROW;
                    state_d    = IDLE;
                end else begin
                    row_d = row_q + 1'b1;
                end
            end
            CLEAR: begin
                clr_d = clr_q + 1'b1;
                if (clr_q == LAST_ROW) begin
                    ptr_d   = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Clear overrides everything, including a result that would show this cycle.
        if (clear_req) begin
            state_d    = CLEAR;
            clr_d      = '0;
            find_valid = 1'b0;
            find_none  = 1'b0;
            next_row   = '0;
            next_col   = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            bmp_q   <= '0;
            row_q   <= '0;
            ptr_q   <= '0;
            clr_q   <= '0;
            qv_q    <= '0;
        end else begin
            state_q <= state_d;
            bmp_q   <= bmp_d;
            row_q   <= row_d;
            ptr_q   <= ptr_d;
            clr_q   <= clr_d;
            qv_q    <= qv_d;
        end
    end

    assign query_visited = qv_q;
    assign find_ready    = (state_q == IDLE);
    assign clear_busy    = (state_q == CLEAR);

`ifdef EDA_VISITED_CNT_EN
    localparam int CNT_W = $clog2(M*N+1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             all_q;

    // set_mask is already empty during CLEAR, so only fresh bits contribute.
    always_comb begin
        cnt_d = cnt_q;
        for (int r = 0; r < M; r++)
            for (int c = 0; c < N; c++)
                cnt_d = cnt_d + CNT_W'(set_mask[r][c] & ~bmp_q[r][c]);
        if (clear_req) cnt_d = '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
            all_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            all_q <= (cnt_d == CNT_W'(M*N));
        end
    end

    assign visited_cnt = cnt_q;
    assign all_visited = all_q;
`endif

endmodule

// File: tb/tb_eda_visited_bitmap.sv
// Directed self-checking bench for eda_visited_bitmap at default parameters (16x16, 9 ports).
module tb_eda_visited_bitmap;
    localparam int M = 16, N = 16, IW = 4, JW = 4, AW = 8, P = 9;

    logic          clk = 1'b0, reset = 1'b1, clear_req = 1'b0, find_req = 1'b0;
    logic [P-1:0]  mark_valid = '0, query_valid = '0;
    logic [P*AW-1:0] mark_addr = '0, query_addr = '0;
    logic          clear_busy, find_ready, find_valid, find_none;
    logic [P-1:0]  query_visited;
    logic [IW-1:0] next_row;
    logic [JW-1:0] next_col;
`ifdef EDA_VISITED_CNT_EN
    logic [$clog2(M*N+1)-1:0] visited_cnt;
    logic                     all_visited;
`endif

    int n_chk = 0, n_pass = 0;

    eda_visited_bitmap dut (
        .clk(clk), .reset(reset), .clear_req(clear_req), .clear_busy(clear_busy),
        .mark_valid(mark_valid), .mark_addr(mark_addr),
        .query_valid(query_valid), .query_addr(query_addr), .query_visited(query_visited),
        .find_req(find_req), .find_ready(find_ready), .find_valid(find_valid),
        .find_none(find_none), .next_row(next_row), .next_col(next_col)
`ifdef EDA_VISITED_CNT_EN
        , .visited_cnt(visited_cnt), .all_visited(all_visited)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Mark every pixel of rows r0..r1, up to P per cycle.
    task automatic mark_rows(input int r0, input int r1);
        int k = 0;
        for (int r = r0; r <= r1; r++) begin
            for (int c = 0; c < N; c++) begin
                mark_valid[k] = 1'b1;
                mark_addr[k*AW +: AW] = AW'(r*N + c);
                k++;
                if (k == P) begin
                    @(negedge clk);
                    mark_valid = '0;
                    k = 0;
                end
            end
        end
        if (k != 0) begin
            @(negedge clk);
            mark_valid = '0;
        end
    endtask

    task automatic mark1(input int r, input int c);
        mark_valid[0] = 1'b1;
        mark_addr[0 +: AW] = AW'(r*N + c);
        @(negedge clk);
        mark_valid = '0;
    endtask

    task automatic query1(input string tag, input int r, input int c, input logic exp);
        query_valid[0] = 1'b1;
        query_addr[0 +: AW] = AW'(r*N + c);
        @(negedge clk);
        query_valid = '0;
        chk(tag, 32'(query_visited[0]), 32'(exp));
    endtask

    // Issue a find and check latency (cycles after the accepting edge) and the result.
    task automatic do_find(input string tag, input int lat, input logic none,
                           input int r, input int c);
        int n = 1;
        chk({tag, "_ready"}, 32'(find_ready), 32'd1);
        find_req = 1'b1;
        @(negedge clk);
        find_req = 1'b0;
        while (!find_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_lat"}, n, lat);
        chk({tag, "_none"}, 32'(find_none), 32'(none));
        if (!none) begin
            chk({tag, "_row"}, 32'(next_row), r);
            chk({tag, "_col"}, 32'(next_col), c);
        end
        @(negedge clk);
    endtask

    initial begin
        int n;
        logic fv_seen;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_ready", 32'(find_ready), 32'd1);
        chk("rst_busy", 32'(clear_busy), 32'd0);
        chk("rst_fv", 32'(find_valid), 32'd0);
        chk("rst_qv", 32'(query_visited), 32'd0);
        chk("rst_row", 32'(next_row), 32'd0);

        do_find("f0", 1, 1'b0, 0, 0);

        // Three ports mark {0,0},{0,1},{0,1}; same-cycle query sees old value.
        mark_valid = 9'b000000111;
        mark_addr[0*AW +: AW] = 8'h00;
        mark_addr[1*AW +: AW] = 8'h01;
        mark_addr[2*AW +: AW] = 8'h01;
        query_valid = 9'b000000001;
        query_addr[0*AW +: AW] = 8'h01;
        @(negedge clk);
        mark_valid = '0;
        query_valid = '0;
        chk("q_rbw", 32'(query_visited[0]), 32'd0);
        query_valid = 9'b000000111;
        query_addr[0*AW +: AW] = 8'h01;
        query_addr[1*AW +: AW] = 8'h00;
        query_addr[2*AW +: AW] = 8'h02;
        @(negedge clk);
        query_valid = '0;
        chk("q_multi", 32'(query_visited[2:0]), 32'b011);
        @(negedge clk);
        chk("q_inval", 32'(query_visited), 32'd0);
`ifdef EDA_VISITED_CNT_EN
        chk("cnt_dup", 32'(visited_cnt), 32'd2);
`endif
        do_find("f1", 1, 1'b0, 0, 2);

        // Rows 0-2 full plus {3,0}: four rows examined.
        mark_rows(0, 2);
        mark1(3, 0);
        do_find("f2", 4, 1'b0, 3, 1);
        do_find("f3", 1, 1'b0, 3, 1);

        // Abort a scan with clear; marks during clear are dropped.
        mark_rows(3, 3);
        find_req = 1'b1;
        @(negedge clk);
        find_req = 1'b0;
        clear_req = 1'b1;
        chk("abort_fv", 32'(find_valid), 32'd0);
        @(negedge clk);
        clear_req = 1'b0;
        n = 0;
        fv_seen = 1'b0;
        while (clear_busy && n < 100) begin
            fv_seen |= find_valid;
            chk("clr_ready", 32'(find_ready), 32'd0);
            if (n == 2) begin
                mark_valid[0] = 1'b1;
                mark_addr[0 +: AW] = 8'h00;
            end else begin
                mark_valid = '0;
            end
            @(negedge clk);
            n++;
        end
        mark_valid = '0;
        chk("clr_cycles", n, M);
        chk("clr_nofv", 32'(fv_seen), 32'd0);
`ifdef EDA_VISITED_CNT_EN
        chk("cnt_clr", 32'(visited_cnt), 32'd0);
`endif
        query1("q_clr00", 0, 0, 1'b0);
        query1("q_clr31", 3, 1, 1'b0);
        do_find("f4", 1, 1'b0, 0, 0);

        // Fill everything: scan from row 0 runs out after M rows.
        mark_rows(0, M-1);
        @(negedge clk);
`ifdef EDA_VISITED_CNT_EN
        chk("cnt_full", 32'(visited_cnt), 32'(M*N));
        chk("all_vis", 32'(all_visited), 32'd1);
`endif
        query1("q_full", M-1, N-1, 1'b1);
        do_find("f5", M, 1'b1, 0, 0);
        do_find("f6", 1, 1'b1, 0, 0);

        // Async reset in the middle of a clear.
        clear_req = 1'b1;
        @(negedge clk);
        clear_req = 1'b0;
        repeat (3) @(negedge clk);
        chk("midclr_busy", 32'(clear_busy), 32'd1);
        reset = 1'b1;
        #1;
        chk("rst_async_busy", 32'(clear_busy), 32'd0);
        chk("rst_async_ready", 32'(find_ready), 32'd1);
        @(negedge clk);
        reset = 1'b0;
        query1("q_rst_ff", M-1, N-1, 1'b0);
        query1("q_rst_88", 8, 8, 1'b0);
        do_find("f7", 1, 1'b0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
